// File: rtl/lnrv_exu_wbck.sv
// Write-back stage: arbitrates ALU and long-pipe results onto the single GPR write port.
// A 1-entry ALU skid buffer lets both source ready signals come straight from a register.
module lnrv_exu_wbck #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_wb_vld,
   output logic                  alu_wb_rdy,
   input  logic [DATA_WIDTH-1:0] alu_wb_data,
   input  logic [RD_WIDTH-1:0]   alu_wb_rd,
   input  logic                  alu_wb_wen,
   input  logic                  lsu_wb_vld,
   output logic                  lsu_wb_rdy,
   input  logic [DATA_WIDTH-1:0] lsu_wb_data,
   input  logic [RD_WIDTH-1:0]   lsu_wb_rd,
   input  logic                  lsu_wb_wen,
   input  logic                  lsu_wb_err,
   output logic                  rf_wen,
   output logic [RD_WIDTH-1:0]   rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  cmt_vld,
   output logic                  cmt_err,
   output logic                  wb_busy
);

   logic                  buf_vld_q, buf_vld_d;
   logic                  buf_wen_q, buf_wen_d;
   logic [RD_WIDTH-1:0]   buf_rd_q, buf_rd_d;
   logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;

   logic                  gnt, gnt_lsu, gnt_wen;
   logic [RD_WIDTH-1:0]   gnt_rd;
   logic [DATA_WIDTH-1:0] gnt_data;

   logic                  rf_wen_q, rf_wen_d;
   logic [RD_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  cmt_vld_q, cmt_vld_d;
   logic                  cmt_err_q, cmt_err_d;

   // Grant: buffered entry first, then long pipe (parking a colliding ALU result), then ALU.
   always_comb begin
      buf_vld_d  = buf_vld_q;
      buf_wen_d  = buf_wen_q;
      buf_rd_d   = buf_rd_q;
      buf_data_d = buf_data_q;
      gnt        = 1'b0;
      gnt_lsu    = 1'b0;
      gnt_wen    = 1'b0;
      gnt_rd     = '0;
      gnt_data   = '0;
      if (buf_vld_q) begin
         gnt       = 1'b1;
         gnt_wen   = buf_wen_q;
         gnt_rd    = buf_rd_q;
         gnt_data  = buf_data_q;
         buf_vld_d = 1'b0;
      end else if (lsu_wb_vld) begin
         gnt      = 1'b1;
         gnt_lsu  = 1'b1;
         gnt_wen  = lsu_wb_wen;
         gnt_rd   = lsu_wb_rd;
         gnt_data = lsu_wb_data;
         if (alu_wb_vld) begin
            buf_vld_d  = 1'b1;
            buf_wen_d  = alu_wb_wen;
            buf_rd_d   = alu_wb_rd;
            buf_data_d = alu_wb_data;
         end
      end else if (alu_wb_vld) begin
         gnt      = 1'b1;
         gnt_wen  = alu_wb_wen;
         gnt_rd   = alu_wb_rd;
         gnt_data = alu_wb_data;
      end
   end

   always_comb begin
      cmt_vld_d  = gnt;
      cmt_err_d  = gnt_lsu & lsu_wb_err;
      rf_wen_d   = gnt & gnt_wen & (gnt_rd != '0) & ~(gnt_lsu & lsu_wb_err);
      rf_waddr_d = gnt ? gnt_rd : rf_waddr_q;
      rf_wdata_d = gnt ? gnt_data : rf_wdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_vld_q  <= 1'b0;
         buf_wen_q  <= 1'b0;
         buf_rd_q   <= '0;
         buf_data_q <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         cmt_vld_q  <= 1'b0;
         cmt_err_q  <= 1'b0;
      end else begin
         buf_vld_q  <= buf_vld_d;
         buf_wen_q  <= buf_wen_d;
         buf_rd_q   <= buf_rd_d;
         buf_data_q <= buf_data_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         cmt_vld_q  <= cmt_vld_d;
         cmt_err_q  <= cmt_err_d;
      end
   end

   assign alu_wb_rdy = ~buf_vld_q;
   assign lsu_wb_rdy = ~buf_vld_q;
   assign wb_busy    = buf_vld_q;
   assign rf_wen     = rf_wen_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign cmt_vld    = cmt_vld_q;
   assign cmt_err    = cmt_err_q;

endmodule

// File: tb/tb_lnrv_exu_wbck.sv
// Scoreboard bench for lnrv_exu_wbck: directed stimulus pushes expected commits,
// a negedge monitor pops and compares each commit the DUT presents.
module tb_lnrv_exu_wbck;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_wb_vld, alu_wb_rdy, alu_wb_wen;
   logic [31:0] alu_wb_data;
   logic [4:0]  alu_wb_rd;
   logic        lsu_wb_vld, lsu_wb_rdy, lsu_wb_wen, lsu_wb_err;
   logic [31:0] lsu_wb_data;
   logic [4:0]  lsu_wb_rd;
   logic        rf_wen, cmt_vld, cmt_err, wb_busy;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   typedef struct packed {
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   lnrv_exu_wbck #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .alu_wb_vld  (alu_wb_vld),
      .alu_wb_rdy  (alu_wb_rdy),
      .alu_wb_data (alu_wb_data),
      .alu_wb_rd   (alu_wb_rd),
      .alu_wb_wen  (alu_wb_wen),
      .lsu_wb_vld  (lsu_wb_vld),
      .lsu_wb_rdy  (lsu_wb_rdy),
      .lsu_wb_data (lsu_wb_data),
      .lsu_wb_rd   (lsu_wb_rd),
      .lsu_wb_wen  (lsu_wb_wen),
      .lsu_wb_err  (lsu_wb_err),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .cmt_vld     (cmt_vld),
      .cmt_err     (cmt_err),
      .wb_busy     (wb_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_wb_vld = 1'b0;
      lsu_wb_vld = 1'b0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data, input logic wen);
      alu_wb_vld  = 1'b1;
      alu_wb_rd   = rd;
      alu_wb_data = data;
      alu_wb_wen  = wen;
   endtask

   task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data, input logic wen,
                            input logic err);
      lsu_wb_vld  = 1'b1;
      lsu_wb_rd   = rd;
      lsu_wb_data = data;
      lsu_wb_wen  = wen;
      lsu_wb_err  = err;
   endtask

   task automatic push(input logic wen, input logic [4:0] addr, input logic [31:0] data,
                       input logic err);
      exp_t x;
      x.wen  = wen;
      x.addr = addr;
      x.data = data;
      x.err  = err;
      sb.push_back(x);
   endtask

   // Monitor: every commit must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (cmt_vld === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_commit: got rd=%0d data=%h, expected no commit",
                     rf_waddr, rf_wdata);
         end else begin
            e = sb.pop_front();
            check("commit_rf_wen", {31'd0, rf_wen}, {31'd0, e.wen});
            check("commit_rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
            check("commit_rf_wdata", rf_wdata, e.data);
            check("commit_cmt_err", {31'd0, cmt_err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      alu_wb_vld  = 1'b0;
      alu_wb_data = '0;
      alu_wb_rd   = '0;
      alu_wb_wen  = 1'b0;
      lsu_wb_vld  = 1'b0;
      lsu_wb_data = '0;
      lsu_wb_rd   = '0;
      lsu_wb_wen  = 1'b0;
      lsu_wb_err  = 1'b0;
      repeat (2) step();
      check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
      check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      check("rst_rf_wdata", rf_wdata, 32'd0);
      check("rst_cmt_vld", {31'd0, cmt_vld}, 32'd0);
      check("rst_cmt_err", {31'd0, cmt_err}, 32'd0);
      check("rst_alu_rdy", {31'd0, alu_wb_rdy}, 32'd1);
      check("rst_lsu_rdy", {31'd0, lsu_wb_rdy}, 32'd1);
      check("rst_wb_busy", {31'd0, wb_busy}, 32'd0);
      reset = 1'b0;
      step();

      // T1: direct ALU write
      drive_alu(5'd5, 32'h0000_1234, 1'b1);
      push(1'b1, 5'd5, 32'h0000_1234, 1'b0);
      step();
      idle();
      step();

      // T2: collision, LSU first, ALU parked for one cycle
      drive_lsu(5'd3, 32'hAAAA_0000, 1'b1, 1'b0);
      drive_alu(5'd7, 32'h0000_5555, 1'b1);
      push(1'b1, 5'd3, 32'hAAAA_0000, 1'b0);
      push(1'b1, 5'd7, 32'h0000_5555, 1'b0);
      step();
      idle();
      check("t2_alu_rdy_c1", {31'd0, alu_wb_rdy}, 32'd0);
      check("t2_lsu_rdy_c1", {31'd0, lsu_wb_rdy}, 32'd0);
      check("t2_busy_c1", {31'd0, wb_busy}, 32'd1);
      step();
      check("t2_alu_rdy_c2", {31'd0, alu_wb_rdy}, 32'd1);
      check("t2_lsu_rdy_c2", {31'd0, lsu_wb_rdy}, 32'd1);
      check("t2_busy_c2", {31'd0, wb_busy}, 32'd0);
      step();

      // T3: rd=0 commits without a write
      drive_alu(5'd0, 32'hFFFF_FFFF, 1'b1);
      push(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      step();
      idle();
      step();

      // T4: faulting long-pipe result
      drive_lsu(5'd9, 32'hDEAD_BEEF, 1'b1, 1'b1);
      push(1'b0, 5'd9, 32'hDEAD_BEEF, 1'b1);
      step();
      idle();
      lsu_wb_err = 1'b0;
      step();

      // T7: long-pipe result with wen=0
      drive_lsu(5'd12, 32'h0BAD_F00D, 1'b0, 1'b0);
      push(1'b0, 5'd12, 32'h0BAD_F00D, 1'b0);
      step();
      idle();
      step();

      // T5: reset while the buffer holds x7; it must never commit
      drive_lsu(5'd3, 32'h1111_2222, 1'b1, 1'b0);
      drive_alu(5'd7, 32'h3333_4444, 1'b1);
      push(1'b1, 5'd3, 32'h1111_2222, 1'b0);
      step();
      idle();
      check("t5_busy_before_rst", {31'd0, wb_busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_busy", {31'd0, wb_busy}, 32'd0);
      check("t5_alu_rdy", {31'd0, alu_wb_rdy}, 32'd1);
      check("t5_lsu_rdy", {31'd0, lsu_wb_rdy}, 32'd1);
      check("t5_rf_wen", {31'd0, rf_wen}, 32'd0);
      check("t5_cmt_vld", {31'd0, cmt_vld}, 32'd0);
      repeat (2) step();

      // T6: four back-to-back ALU writes
      for (int i = 1; i <= 4; i++) begin
         drive_alu(5'(i), 32'h111 * i, 1'b1);
         push(1'b1, 5'(i), 32'h111 * i, 1'b0);
         check("t6_alu_rdy", {31'd0, alu_wb_rdy}, 32'd1);
         step();
      end
      idle();
      check("t6_alu_rdy_end", {31'd0, alu_wb_rdy}, 32'd1);
      repeat (3) step();

      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
